// File: rtl/rx_receiver.sv
// rx_receiver: serial frame receiver. Hunts preamble+SFD, deserialises header/payload/CRC-8
// and holds the frame under a valid/ack handshake. Define RX_CRC_CHECK_EN to enable the CRC check.

`ifdef RX_CRC_CHECK_EN
module crc8_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       data_in,
    output logic [7:0] crc_out
);
    logic [7:0] r_crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // One CRC-8 (poly 0x07) step per enabled bit; clear has priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crc <= 8'h00;
        end else if (clear) begin
            r_crc <= 8'h00;
        end else if (enable) begin
            r_crc <= crc8_step(r_crc, data_in);
        end else begin
            r_crc <= r_crc;
        end
    end

    assign crc_out = r_crc;
endmodule
`endif

module rx_receiver #(
    parameter logic [15:0] PREAMBLE_PATTERN = 16'hAAAA,
    parameter logic [7:0]  SFD_PATTERN      = 8'hAB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_line,
    input  logic         rx_ack,
    output logic [135:0] rx_packet,
    output logic         rx_valid,
    output logic         crc_err,
    output logic         overrun,
    output logic         rx_busy
);
    typedef enum logic [2:0] {
        S_HUNT   = 3'd0,
        S_HEADER = 3'd1,
        S_DATA   = 3'd2,
        S_CRC    = 3'd3,
        S_CHECK  = 3'd4
    } state_t;

    state_t         r_state;
    logic [23:0]    r_window;
    logic [7:0]     r_bit_cnt;
    logic [7:0]     r_header;
    logic [3:0]     r_len;
    logic [127:0]   r_payload;
    logic [135:0]   r_packet;
    logic           r_valid;
    logic           r_overrun;

    logic           w_sync_hit;
    logic           w_crc_ok;
    logic [7:0]     w_header_next;
    logic [7:0]     w_data_last;
    logic [6:0]     w_pidx;

    assign w_sync_hit    = ({r_window[22:0], rx_line} == {PREAMBLE_PATTERN, SFD_PATTERN});
    assign w_header_next = {r_header[6:0], rx_line};
    // (len+1)*8-1 == len*8+7
    assign w_data_last   = {1'b0, r_len, 3'b111};
    assign w_pidx        = 7'd127 - r_bit_cnt[6:0];

`ifdef RX_CRC_CHECK_EN
    logic [7:0] r_rx_crc;
    logic [7:0] w_crc_out;
    logic       r_crc_err;

    crc8_serial u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (r_state == S_HUNT && w_sync_hit),
        .enable  (r_state == S_DATA),
        .data_in (rx_line),
        .crc_out (w_crc_out)
    );

    // Received CRC byte shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_crc <= 8'h00;
        end else if (r_state == S_CRC) begin
            r_rx_crc <= {r_rx_crc[6:0], rx_line};
        end else begin
            r_rx_crc <= r_rx_crc;
        end
    end

    // CRC error pulse, one cycle after the check state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_crc_err <= 1'b0;
        end else begin
            r_crc_err <= (r_state == S_CHECK) && !w_crc_ok;
        end
    end

    assign w_crc_ok = (r_rx_crc == w_crc_out);
    assign crc_err  = r_crc_err;
`else
    assign w_crc_ok = 1'b1;
    assign crc_err  = 1'b0;
`endif

    // Frame FSM, deserialiser and output handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_HUNT;
            r_window  <= 24'h000000;
            r_bit_cnt <= 8'd0;
            r_header  <= 8'h00;
            r_len     <= 4'd0;
            r_payload <= 128'd0;
            r_packet  <= 136'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_valid && rx_ack) begin
                r_valid <= 1'b0;
            end
            case (r_state)
                S_HUNT: begin
                    if (w_sync_hit) begin
                        r_state   <= S_HEADER;
                        r_bit_cnt <= 8'd0;
                        r_payload <= 128'd0;
                        r_window  <= 24'h000000;
                    end else begin
                        r_window  <= {r_window[22:0], rx_line};
                    end
                end
                S_HEADER: begin
                    r_header <= w_header_next;
                    if (r_bit_cnt == 8'd7) begin
                        r_len     <= w_header_next[3:0];
                        r_state   <= S_DATA;
                        r_bit_cnt <= 8'd0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                    end
                end
                S_DATA: begin
                    r_payload[w_pidx] <= rx_line;
                    if (r_bit_cnt == w_data_last) begin
                        r_state   <= S_CRC;
                        r_bit_cnt <= 8'd0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                    end
                end
                S_CRC: begin
                    if (r_bit_cnt == 8'd7) begin
                        r_state   <= S_CHECK;
                        r_bit_cnt <= 8'd0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    r_state <= S_HUNT;
                    if (!w_crc_ok) begin
                        r_overrun <= 1'b0;
                    end else if (r_valid && !rx_ack) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_packet <= {r_header, r_payload};
                        r_valid  <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_HUNT;
                    r_bit_cnt <= 8'd0;
                    r_window  <= 24'h000000;
                end
            endcase
        end
    end

    assign rx_packet = r_packet;
    assign rx_valid  = r_valid;
    assign overrun   = r_overrun;
    assign rx_busy   = (r_state != S_HUNT);
endmodule

// File: tb/tb_rx_receiver.sv
// Self-checking bench for rx_receiver: bit-stream reference model compared every cycle,
// directed frames from the test plan plus randomized frames, gaps and acks.

module tb_rx_receiver;
    localparam logic [15:0] PRE = 16'hAAAA;
    localparam logic [7:0]  SFD = 8'hAB;
`ifdef RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b0;
    logic         rx_line = 1'b0;
    logic         rx_ack  = 1'b0;
    logic [135:0] rx_packet;
    logic         rx_valid;
    logic         crc_err;
    logic         overrun;
    logic         rx_busy;

    int n_checks = 0;
    int n_err    = 0;

    rx_receiver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_line   (rx_line),
        .rx_ack    (rx_ack),
        .rx_packet (rx_packet),
        .rx_valid  (rx_valid),
        .crc_err   (crc_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkp(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-wise CRC-8/0x07 over the first nbytes of a left-aligned payload
    function automatic logic [7:0] crc8_bytes(input logic [127:0] pl, input int nbytes);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            c = c ^ pl[127 - 8*i -: 8];
            for (int k = 0; k < 8; k++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic logic rnd_ack();
        return ($urandom_range(0, 3) == 0);
    endfunction

    // ---------------- reference model ----------------
    logic [23:0]  m_hist   = 24'h0;
    bit           m_in_frame = 1'b0;
    bit           m_chk    = 1'b0;
    logic         m_bits[$];
    int           m_need   = 1000;
    logic         m_valid  = 1'b0;
    logic         m_err    = 1'b0;
    logic         m_ovr    = 1'b0;
    logic [135:0] m_pkt    = 136'd0;

    task automatic model_step(input logic r, input logic b, input logic a);
        logic [7:0]   hdr;
        logic [7:0]   crc_rx;
        logic [127:0] pl;
        int           nb;
        bit           ok;
        if (!r) begin
            m_hist = 24'h0; m_in_frame = 1'b0; m_chk = 1'b0; m_bits.delete();
            m_need = 1000; m_valid = 1'b0; m_err = 1'b0; m_ovr = 1'b0; m_pkt = 136'd0;
            return;
        end
        m_err = 1'b0;
        m_ovr = 1'b0;
        if (m_chk) begin
            m_chk = 1'b0;
            for (int i = 0; i < 8; i++) hdr[7-i] = m_bits[i];
            nb = int'(hdr[3:0]) + 1;
            pl = 128'd0;
            for (int i = 0; i < nb*8; i++) pl[127-i] = m_bits[8+i];
            for (int i = 0; i < 8; i++) crc_rx[7-i] = m_bits[8 + nb*8 + i];
            ok = CRC_ON ? (crc8_bytes(pl, nb) == crc_rx) : 1'b1;
            if (!ok) begin
                m_err = 1'b1;
                if (m_valid && a) m_valid = 1'b0;
            end else if (m_valid && !a) begin
                m_ovr = 1'b1;
            end else begin
                m_pkt   = {hdr, pl};
                m_valid = 1'b1;
            end
        end else begin
            if (m_valid && a) m_valid = 1'b0;
            if (m_in_frame) begin
                m_bits.push_back(b);
                if (m_bits.size() == 8)
                    m_need = 16 + 8 * (int'({m_bits[4], m_bits[5], m_bits[6], m_bits[7]}) + 1);
                if (m_bits.size() == m_need) begin
                    m_in_frame = 1'b0;
                    m_chk      = 1'b1;
                end
            end else begin
                m_hist = {m_hist[22:0], b};
                if (m_hist == {PRE, SFD}) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                    m_need = 1000;
                    m_hist = 24'h0;
                end
            end
        end
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step(rst_n, rx_line, rx_ack);
            chk1("rx_valid", rx_valid, m_valid);
            chk1("crc_err", crc_err, m_err);
            chk1("overrun", overrun, m_ovr);
            chk1("rx_busy", rx_busy, m_in_frame || m_chk);
            chkp("rx_packet", rx_packet, m_pkt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic b, input logic a);
        @(negedge clk);
        rx_line = b;
        rx_ack  = a;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] pl, input logic [7:0] crc,
                              input bit rand_ack, input logic check_ack);
        logic [23:0] sync;
        int nbits;
        sync  = {PRE, SFD};
        nbits = (int'(hdr[3:0]) + 1) * 8;
        for (int i = 23; i >= 0; i--) tick(sync[i], rand_ack ? rnd_ack() : 1'b0);
        for (int i = 7; i >= 0; i--)  tick(hdr[i],  rand_ack ? rnd_ack() : 1'b0);
        for (int i = 0; i < nbits; i++) tick(pl[127-i], rand_ack ? rnd_ack() : 1'b0);
        for (int i = 7; i >= 0; i--)  tick(crc[i],  rand_ack ? rnd_ack() : 1'b0);
        tick(1'($urandom_range(0, 1)), check_ack);
    endtask

    initial begin
        logic [127:0] pl;
        logic [7:0]   hdr;
        logic [7:0]   crc;
        logic [23:0]  sync;
        int           nb;

        repeat (3) tick(1'b0, 1'b0);
        @(posedge clk); #2;
        chk1("rst_valid", rx_valid, 1'b0);
        chk1("rst_busy", rx_busy, 1'b0);
        chk1("rst_crc_err", crc_err, 1'b0);
        chk1("rst_overrun", overrun, 1'b0);
        chkp("rst_packet", rx_packet, 136'd0);
        rst_n = 1'b1;

        repeat (100) tick(1'b0, rnd_ack());
        chk1("idle_busy", rx_busy, 1'b0);

        chk8("pin_crc_55", crc8_bytes({8'h55, 120'd0}, 1), 8'hAC);
        chk8("pin_crc_01", crc8_bytes({8'h01, 120'd0}, 1), 8'h07);

        // Good frame
        send_frame(8'h30, {8'h55, 120'd0}, 8'hAC, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk1("good_valid", rx_valid, 1'b1);
        chkp("good_packet", rx_packet, {8'h30, 8'h55, 120'd0});
        tick(1'b0, 1'b1);
        @(posedge clk); #2;
        chk1("ack_clears", rx_valid, 1'b0);
        tick(1'b0, 1'b0);

        // Bad CRC byte, then inverted first payload bit
        send_frame(8'h30, {8'h55, 120'd0}, 8'hAD, 1'b0, 1'b0);
        @(posedge clk); #2;
`ifdef RX_CRC_CHECK_EN
        chk1("badcrc_err", crc_err, 1'b1);
        chk1("badcrc_valid", rx_valid, 1'b0);
`else
        chk1("nocrc_err", crc_err, 1'b0);
        chkp("nocrc_packet", rx_packet, {8'h30, 8'h55, 120'd0});
`endif
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        send_frame(8'h30, {8'hD5, 120'd0}, 8'hAC, 1'b0, 1'b0);
        @(posedge clk); #2;
`ifdef RX_CRC_CHECK_EN
        chk1("badbit_err", crc_err, 1'b1);
        chk1("badbit_valid", rx_valid, 1'b0);
`else
        chk1("nocrc_bit_valid", rx_valid, 1'b1);
        chkp("nocrc_bit_packet", rx_packet, {8'h30, 8'hD5, 120'd0});
`endif
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // Maximum-length frame
        send_frame(8'h0F, 128'd0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk1("max_valid", rx_valid, 1'b1);
        chkp("max_packet", rx_packet, {8'h0F, 128'd0});
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // Overrun: second good frame while first is unacked, back-to-back
        pl = {8'h12, 8'h34, 112'd0};
        send_frame(8'h01, pl, crc8_bytes(pl, 2), 1'b0, 1'b0);
        send_frame(8'h30, {8'h55, 120'd0}, 8'hAC, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk1("ovr_pulse", overrun, 1'b1);
        chk1("ovr_valid", rx_valid, 1'b1);
        chkp("ovr_kept", rx_packet, {8'h01, 8'h12, 8'h34, 112'd0});
        // Ack in the check cycle: new frame replaces the held one
        send_frame(8'h30, {8'h55, 120'd0}, 8'hAC, 1'b0, 1'b1);
        @(posedge clk); #2;
        chk1("repl_no_ovr", overrun, 1'b0);
        chk1("repl_valid", rx_valid, 1'b1);
        chkp("repl_packet", rx_packet, {8'h30, 8'h55, 120'd0});
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // Reset during payload
        sync = {PRE, SFD};
        for (int i = 23; i >= 0; i--) tick(sync[i], 1'b0);
        hdr = 8'h31;
        for (int i = 7; i >= 0; i--) tick(hdr[i], 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk1("midrst_busy", rx_busy, 1'b0);
        chk1("midrst_valid", rx_valid, 1'b0);
        rst_n = 1'b1;
        send_frame(8'h30, {8'h55, 120'd0}, 8'hAC, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk1("postrst_valid", rx_valid, 1'b1);
        chkp("postrst_packet", rx_packet, {8'h30, 8'h55, 120'd0});

        // Randomized frames, acks and gaps
        for (int f = 0; f < 40; f++) begin
            hdr = 8'($urandom);
            nb  = int'(hdr[3:0]) + 1;
            pl  = {$urandom, $urandom, $urandom, $urandom};
            crc = crc8_bytes(pl, nb);
            if ($urandom_range(0, 3) == 0) crc = crc ^ (8'd1 << $urandom_range(0, 7));
            send_frame(hdr, pl, crc, 1'b1, rnd_ack());
            repeat ($urandom_range(0, 4)) tick(($urandom_range(0, 7) == 0), rnd_ack());
        end

        repeat (5) tick(1'b0, 1'b0);
        @(posedge clk); #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/rx_receiver.md
# rx_receiver

Serial frame receiver for the CRC network link. It samples the one-bit line driven by the link transmitter once per clock, hunts for the 16-bit preamble plus SFD, then deserialises header, payload and CRC-8. It checks the CRC and presents the frame on a 136-bit parallel bus held under a valid/ack handshake. It sits at the receive end of the link and feeds the packet-handling logic.

## Interface
- PREAMBLE_PATTERN, 16'hAAAA, preamble bits, MSB first on the line
- SFD_PATTERN, 8'hAB, start-of-frame delimiter, MSB first
- clk  input  1  clock; one line bit per rising edge
- rst_n  input  1  reset. Synchronous active-low; clears all state on a clk edge where it is low.
- rx_line  input  1  serial line, 1 bit/clk, idles 0
- rx_ack  input  1  consumer acknowledges the held frame
- rx_packet  output  136  [135:128] header, [127:0] payload, left-aligned, unused low bytes 0
- rx_valid  output  1  frame held in rx_packet, level until acked
- crc_err  output  1  one-cycle pulse: frame failed CRC, discarded
- overrun  output  1  one-cycle pulse: good frame dropped because the previous frame was unacked
- rx_busy  output  1  high in every state except S_HUNT

## Operation
- Frame on line, MSB first for every field:
  - preamble (16 bits)
  - SFD (8 bits)
  - header (8 bits); header[3:0] = len
  - payload, (len+1)*8 bits (8..128)
  - CRC-8 (8 bits)
- CRC: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR. It covers payload bits only. Computed with crc8_serial (clear, enable, data_in, crc_out).
- States:
  - S_HUNT
    - 24-bit window shifts in rx_line every clk.
    - When {window[22:0], rx_line} == {PREAMBLE_PATTERN, SFD_PATTERN}: go to S_HEADER with bit_cnt=0, clear the payload register to 0, pulse crc8 clear.
    - The window is zeroed on every entry to S_HUNT.
  - S_HEADER
    - 8 bits shift into the header register.
    - At bit_cnt==7: latch len from the completed header, go to S_DATA, bit_cnt=0.
  - S_DATA
    - Bit stored at payload[127-bit_cnt]; crc8 enable=1, data_in=rx_line.
    - At bit_cnt==(len+1)*8-1: go to S_CRC. Compare width is 8 bits, no overflow, max 127.
  - S_CRC
    - 8 bits shift into rx_crc.
    - At bit_cnt==7: go to S_CHECK.
  - S_CHECK (1 cycle), always returns to S_HUNT:
    - If rx_crc != crc_out: crc_err=1; rx_packet and rx_valid unchanged.
    - Else if rx_valid==1 and rx_ack==0: overrun=1; frame dropped.
    - Else: rx_packet={header,payload}, rx_valid=1.
- Handshake:
  - rx_ack sampled while rx_valid=1 clears rx_valid on that edge, unless S_CHECK loads a new frame on the same edge. In that case rx_valid stays 1 and rx_packet takes the new frame.
  - rx_ack with rx_valid=0 is ignored.
- Line activity during S_HEADER..S_CRC is consumed as frame bits; no resync mid-frame.
- Reset mid-frame: on the next edge with rst_n=0, state is S_HUNT and the partial frame is lost.

## Timing
- Reset values:
  - rx_packet=0, rx_valid=0, crc_err=0, overrun=0, rx_busy=0
  - state=S_HUNT, bit_cnt=0, window=0
- Edge E samples the final SFD bit; edge E+1 samples header bit 7.
- Edge L samples the final CRC bit. S_CHECK occupies cycle L..L+1. rx_valid, crc_err or overrun are visible after edge L+1. Latency from last CRC bit is 1 cycle.
- crc_err and overrun are high for exactly one cycle.
- Back-to-back frames: hunting resumes the cycle after S_CHECK. A preamble starting at edge L+2 is detected.

## Configuration
- RX_CRC_CHECK_EN
  - Defined: CRC checked as above.
  - Undefined:
    - crc8_serial not instantiated and crc_err tied 0.
    - The 8 CRC bits are still consumed in S_CRC.
    - Every frame takes the good-CRC path in S_CHECK.

## Test plan
- Reset, then idle line 0 for 100 clks: rx_valid=0, rx_busy=0, no pulses.
- Good frame: preamble+SFD, header 0x30, payload 0x55, CRC 0xAC. Expect rx_valid one cycle after last CRC bit, rx_packet={8'h30,8'h55,120'h0}. rx_ack clears rx_valid.
- Same frame with CRC 0xAD, or first payload bit inverted: crc_err pulse, rx_valid stays 0. With RX_CRC_CHECK_EN undefined: frame delivered, crc_err=0.
- Max frame, header 0x0F, 16 bytes payload 0x00, CRC 0x00: rx_packet[127:0]=0, header 0x0F, valid after 16+8+8+128+8 bits.
- Two good frames, no rx_ack: first frame is held, overrun pulses at second frame's S_CHECK. Repeat with rx_ack asserted in that exact cycle: second frame replaces the first, rx_valid stays 1.
- rst_n low for 1 clk during S_DATA: rx_busy=0 next cycle, no rx_valid. The following clean frame is received correctly.
